// File: rtl/requant_output_pack.sv
// requant_output_pack: adds the output zero point to requantized int32 results,
// clamps them to the activation range as int8, packs four bytes little-endian
// per 32-bit word and queues the words in a small first-word-fall-through FIFO.
module requant_output_pack #(
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] num_elements_i,
    input  logic [31:0] output_zero_point_i,
    input  logic [7:0]  act_min_i,
    input  logic [7:0]  act_max_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        almost_full_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [3:0]  out_keep_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q;
    logic [31:0]   num_q, zp_q, acc_cnt_q;
    logic [7:0]    min_q, max_q;
    logic          v0_q, l0_q, v1_q, l1_q;
    logic [31:0]   d0_q;
    logic [7:0]    b1_q;
    logic [1:0]    lane_q;
    logic [31:0]   pack_q;
    logic [3:0]    keep_q;
    logic [31:0]   mem_data_q [FIFO_DEPTH];
    logic [3:0]    mem_keep_q [FIFO_DEPTH];
    logic          mem_last_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    logic               start_ok, accept, push, pop, full, wr_en, drop, head_valid;
    logic signed [32:0] sum, lo, hi;
    logic [7:0]         clamped;
    logic [31:0]        word_data;
    logic [3:0]         word_keep;

    assign start_ok   = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign accept     = in_valid_i && (state_q == S_RUN) && (acc_cnt_q < num_q);
    assign head_valid = (cnt_q != '0);
    assign full       = (cnt_q == CW'(FIFO_DEPTH));
    assign pop        = head_valid && out_ready_i;
    assign push       = v1_q && ((lane_q == 2'(PACK - 1)) || l1_q);
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;

    // 33-bit zero-point add so large inputs saturate instead of wrapping, then clamp.
    always_comb begin
        sum     = $signed({d0_q[31], d0_q}) + $signed({zp_q[31], zp_q});
        lo      = $signed({{25{min_q[7]}}, min_q});
        hi      = $signed({{25{max_q[7]}}, max_q});
        clamped = sum[7:0];
        if (sum < lo)
            clamped = min_q;
        else if (sum > hi)
            clamped = max_q;
    end

    // Merge the incoming byte into the partially filled word being assembled.
    always_comb begin
        word_data = pack_q;
        word_keep = keep_q;
        word_data[{lane_q, 3'b000} +: 8] = b1_q;
        word_keep[lane_q] = 1'b1;
    end

    // Config latch, element counter and the two pipeline stages feeding the packer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_q     <= '0;
            zp_q      <= '0;
            min_q     <= '0;
            max_q     <= '0;
            acc_cnt_q <= '0;
            v0_q      <= 1'b0;
            l0_q      <= 1'b0;
            d0_q      <= '0;
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            b1_q      <= '0;
        end else begin
            if (start_ok) begin
                num_q     <= num_elements_i;
                zp_q      <= output_zero_point_i;
                min_q     <= act_min_i;
                max_q     <= act_max_i;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
            v0_q <= accept;
            l0_q <= accept && (acc_cnt_q == num_q - 32'd1);
            d0_q <= in_data_i;
            v1_q <= v0_q;
            l1_q <= l0_q;
            b1_q <= clamped;
        end
    end

    // Lane packer: accumulate bytes until the word is full or the job ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q <= '0;
            pack_q <= '0;
            keep_q <= '0;
        end else if (start_ok || push) begin
            lane_q <= '0;
            pack_q <= '0;
            keep_q <= '0;
        end else if (v1_q) begin
            lane_q <= lane_q + 2'd1;
            pack_q <= word_data;
            keep_q <= word_keep;
        end
    end

    // Output FIFO; a push into a full FIFO without a pop is dropped and flagged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_keep_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_data_q[wr_q] <= word_data;
                mem_keep_q[wr_q] <= word_keep;
                mem_last_q[wr_q] <= l1_q;
                wr_q             <= wr_q + AW'(1);
            end
            if (pop)
                rd_q <= rd_q + AW'(1);
            if (wr_en && !pop)
                cnt_q <= cnt_q + CW'(1);
            else if (pop && !wr_en)
                cnt_q <= cnt_q - CW'(1);
            if (start_ok)
                ovf_q <= 1'b0;
            else if (drop)
                ovf_q <= 1'b1;
        end
    end

    // Job sequencer; a dropped final word ends the job directly since it can never handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i)
                        state_q <= (num_elements_i == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (push && l1_q)
                        state_q <= wr_en ? S_DRAIN : S_DONE;
                end
                S_DRAIN: begin
                    if (pop && mem_last_q[rd_q])
                        state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid_o    = head_valid;
    assign out_data_o     = head_valid ? mem_data_q[rd_q] : '0;
    assign out_keep_o     = head_valid ? mem_keep_q[rd_q] : '0;
    assign out_last_o     = head_valid && mem_last_q[rd_q];
    assign almost_full_o  = (cnt_q >= CW'(FIFO_DEPTH - AF_MARGIN));
    assign busy_o         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o         = (state_q == S_DONE);
    assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_requant_output_pack.sv
// Directed bench for requant_output_pack: packing, clamping, FIFO overflow,
// zero-length jobs, ignored restarts and asynchronous reset.
module tb_requant_output_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_elements;
    logic [31:0] output_zero_point;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic        in_valid;
    logic [31:0] in_data;
    logic        almost_full;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    requant_output_pack dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .num_elements_i      (num_elements),
        .output_zero_point_i (output_zero_point),
        .act_min_i           (act_min),
        .act_max_i           (act_max),
        .in_valid_i          (in_valid),
        .in_data_i           (in_data),
        .almost_full_o       (almost_full),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_data_o          (out_data),
        .out_keep_o          (out_keep),
        .out_last_o          (out_last),
        .busy_o              (busy),
        .done_o              (done),
        .overflow_err_o      (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_job(input logic [31:0] n, input logic [31:0] zp,
                             input logic [7:0] mn, input logic [7:0] mx);
        num_elements      = n;
        output_zero_point = zp;
        act_min           = mn;
        act_max           = mx;
        start             = 1'b1;
        tick();
        start             = 1'b0;
    endtask

    // Check the head word, then accept it with a one-cycle ready pulse.
    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_keep"}, 32'(out_keep), 32'(k));
        chk({tag, "_last"}, 32'(out_last), 32'(l));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_elements = '0; output_zero_point = '0;
        act_min = '0; act_max = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        rst = 1'b0;
        tick();

        // Job 1: zp=-128; 0->0x80, 100->0xE4, 200->72=0x48, -300->-428 clamps to 0x80.
        begin_job(32'd4, 32'hFFFF_FF80, 8'h80, 8'h7F);
        chk("j1_busy", 32'(busy), 32'd1);
        feed(32'd0);
        feed(32'd100);
        feed(32'd200);
        feed(32'hFFFF_FED4);
        tick();
        chk("j1_lat_valid", 32'(out_valid), 32'd0);
        tick();
        expect_word("j1_w0", 32'h8048_E480, 4'hF, 1'b1);
        chk("j1_done", 32'(done), 32'd1);
        chk("j1_busy_end", 32'(busy), 32'd0);

        // Job 2: six elements -> one full word and one partial word.
        begin_job(32'd6, 32'd0, 8'h80, 8'h7F);
        for (int i = 1; i <= 6; i++) feed(32'(i));
        repeat (4) tick();
        expect_word("j2_w0", 32'h0403_0201, 4'hF, 1'b0);
        expect_word("j2_w1", 32'h0000_0605, 4'h3, 1'b1);
        chk("j2_done", 32'(done), 32'd1);

        // Job 3: sums beyond 32 bits must saturate, not wrap.
        begin_job(32'd2, 32'd1, 8'h80, 8'h7F);
        feed(32'h7FFF_FFFF);
        feed(32'h8000_0000);
        repeat (3) tick();
        expect_word("j3_w0", 32'h0000_807F, 4'h3, 1'b1);

        // Job 4: narrow range [-10,20]: 50->0x14, -50->0xF6, 5->0x05, -3->0xFD.
        begin_job(32'd4, 32'd0, 8'hF6, 8'h14);
        feed(32'd50);
        feed(32'hFFFF_FFCE);
        feed(32'd5);
        feed(32'hFFFF_FFFD);
        repeat (3) tick();
        expect_word("j4_w0", 32'hFD05_F614, 4'hF, 1'b1);

        // Job 5: 20 words with the consumer stalled; only four fit.
        begin_job(32'd80, 32'd0, 8'h80, 8'h7F);
        for (int i = 0; i < 80; i++) begin
            feed(32'(i));
            if (i == 8) chk("j5_af_low", 32'(almost_full), 32'd0);
            if (i == 9) chk("j5_af_high", 32'(almost_full), 32'd1);
        end
        repeat (4) tick();
        chk("j5_ovf", 32'(overflow_err), 32'd1);
        chk("j5_done", 32'(done), 32'd1);
        chk("j5_af_full", 32'(almost_full), 32'd1);
        for (int w = 0; w < 4; w++)
            expect_word("j5_w", {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF, 1'b0);
        chk("j5_empty", 32'(out_valid), 32'd0);
        chk("j5_af_clr", 32'(almost_full), 32'd0);
        chk("j5_ovf_sticky", 32'(overflow_err), 32'd1);

        // Zero-length job finishes at once and clears the overflow flag.
        begin_job(32'd0, 32'd0, 8'h80, 8'h7F);
        chk("z_done", 32'(done), 32'd1);
        chk("z_ovf", 32'(overflow_err), 32'd0);
        tick();
        chk("z_valid", 32'(out_valid), 32'd0);

        // A start during RUN must not disturb the running job.
        begin_job(32'd2, 32'd0, 8'h80, 8'h7F);
        feed(32'd7);
        num_elements = 32'd1; output_zero_point = 32'd100; start = 1'b1;
        tick();
        start = 1'b0;
        feed(32'd9);
        repeat (3) tick();
        expect_word("ign_w0", 32'h0000_0907, 4'h3, 1'b1);
        chk("ign_done", 32'(done), 32'd1);

        // Asynchronous reset in the middle of a job.
        begin_job(32'd8, 32'd0, 8'h80, 8'h7F);
        for (int i = 1; i <= 5; i++) feed(32'(i));
        repeat (2) tick();
        chk("r_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("r_valid", 32'(out_valid), 32'd0);
        chk("r_data", out_data, 32'd0);
        chk("r_keep", 32'(out_keep), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_done", 32'(done), 32'd0);
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("r_post_valid", 32'(out_valid), 32'd0);
        chk("r_post_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
